p_out_reg: RTL and testbench

Output stage of the DSP slice and the far end of the cascade chain that the B input registers feed.
- Takes the ALU result and carry bits and registers them into P under PREG/CEP/RSTP.
- Drives the PCOUT cascade to the next slice.
- Performs pattern/pattern-bar detection, overflow/underflow detection and optional auto-reset of P.

---
 rtl/dsp_pkg.sv | 31 +++
 rtl/dsp_pattern_detect.sv | 27 ++
 rtl/p_out_reg.sv | 139 +++++++++++++
 tb/tb_p_out_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared widths, default constants and legal string-parameter
//                values for the DSP slice output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_pkg;

    localparam int P_W     = 48;
    localparam int CARRY_W = 4;
    localparam int C_W     = 48;

    localparam logic [P_W-1:0] DEFAULT_MASK = 48'h3FFF_FFFF_FFFF;

    // USE_PATTERN_DETECT
    localparam string PATDET_ON      = "PATDET";
    localparam string PATDET_OFF     = "NO_PATDET";
    // SEL_PATTERN / SEL_MASK
    localparam string SEL_FROM_C     = "C";
    localparam string SEL_PAT_STATIC = "PATTERN";
    localparam string SEL_MSK_STATIC = "MASK";
    // AUTORESET_PATDET
    localparam string AR_NONE        = "NO_RESET";
    localparam string AR_MATCH       = "RESET_MATCH";
    localparam string AR_NOT_MATCH   = "RESET_NOT_MATCH";

endpackage : dsp_pkg

`default_nettype wire

// File: rtl/dsp_pattern_detect.sv
// ============================================================================
//  Module      : dsp_pattern_detect
//  Description : Combinational masked compare of a value against a pattern
//                and its inverse. A mask bit of 1 excludes that bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_pattern_detect
    import dsp_pkg::*;
(
    input  logic [P_W-1:0] i_value,
    input  logic [P_W-1:0] i_pattern,
    input  logic [P_W-1:0] i_mask,
    output logic           o_pd,
    output logic           o_pbd
);

    logic [P_W-1:0] w_diff;

    assign w_diff = i_value ^ i_pattern;
    assign o_pd   = &(~w_diff | i_mask);
    assign o_pbd  = &(w_diff | i_mask);

endmodule : dsp_pattern_detect

`default_nettype wire

// File: rtl/p_out_reg.sv
// ============================================================================
//  Module      : p_out_reg
//  Description : DSP slice P output stage: P/CARRYOUT register, PCOUT cascade,
//                pattern detect, auto-reset and overflow/underflow flags.
//                Optional macro DSP_P_OVF_UNF_EN builds the overflow/underflow
//                history registers; without it OVERFLOW/UNDERFLOW are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p_out_reg
    import dsp_pkg::*;
#(
    parameter int             PREG               = 1,
    parameter string          USE_PATTERN_DETECT = "NO_PATDET",
    parameter logic [P_W-1:0] PATTERN            = '0,
    parameter logic [P_W-1:0] MASK               = DEFAULT_MASK,
    parameter string          SEL_PATTERN        = "PATTERN",
    parameter string          SEL_MASK           = "MASK",
    parameter string          AUTORESET_PATDET   = "NO_RESET"
) (
    input  logic               clk,
    input  logic               RSTP,
    input  logic               CEP,
    input  logic [P_W-1:0]     ALU_OUT,
    input  logic [CARRY_W-1:0] CARRYOUT_IN,
    input  logic [C_W-1:0]     C,
    output logic [P_W-1:0]     P,
    output logic [P_W-1:0]     PCOUT,
    output logic [CARRY_W-1:0] CARRYOUT,
    output logic               PATTERNDETECT,
    output logic               PATTERNBDETECT,
    output logic               OVERFLOW,
    output logic               UNDERFLOW
);

    localparam bit c_patdet_en    = (USE_PATTERN_DETECT == PATDET_ON);
    localparam bit c_ar_match     = c_patdet_en && (AUTORESET_PATDET == AR_MATCH);
    localparam bit c_ar_not_match = c_patdet_en && (AUTORESET_PATDET == AR_NOT_MATCH);

    logic [P_W-1:0] w_pat;
    logic [P_W-1:0] w_msk;
    logic           w_pd_raw;
    logic           w_pbd_raw;
    logic           w_pd_d;
    logic           w_pbd_d;
    logic           w_unused_c;

    assign w_pat      = (SEL_PATTERN == SEL_FROM_C) ? C : PATTERN;
    assign w_msk      = (SEL_MASK == SEL_FROM_C) ? C : MASK;
    assign w_unused_c = ^C;

    dsp_pattern_detect u_detect (
        .i_value   (ALU_OUT),
        .i_pattern (w_pat),
        .i_mask    (w_msk),
        .o_pd      (w_pd_raw),
        .o_pbd     (w_pbd_raw)
    );

    assign w_pd_d  = c_patdet_en & w_pd_raw;
    assign w_pbd_d = c_patdet_en & w_pbd_raw;

    generate
        if (PREG != 0) begin : g_preg
            logic [P_W-1:0]     r_p;
            logic [CARRY_W-1:0] r_carry;
            logic               r_pd;
            logic               r_pbd;
            logic               w_autoreset;

            // Auto-reset looks at the registered flag, i.e. the result already on P.
            assign w_autoreset = (c_ar_match && r_pd) || (c_ar_not_match && !r_pd);

            always_ff @(posedge clk) begin
                if (RSTP) begin
                    r_p     <= '0;
                    r_carry <= '0;
                    r_pd    <= 1'b0;
                    r_pbd   <= 1'b0;
                end else if (CEP) begin
                    if (w_autoreset) begin
                        r_p     <= '0;
                        r_carry <= '0;
                        r_pd    <= 1'b0;
                        r_pbd   <= 1'b0;
                    end else begin
                        r_p     <= ALU_OUT;
                        r_carry <= CARRYOUT_IN;
                        r_pd    <= w_pd_d;
                        r_pbd   <= w_pbd_d;
                    end
                end
            end

`ifdef DSP_P_OVF_UNF_EN
            logic r_pd_past;
            logic r_pbd_past;

            // Both auto-reset and normal load shift the current flags into history.
            always_ff @(posedge clk) begin
                if (RSTP) begin
                    r_pd_past  <= 1'b0;
                    r_pbd_past <= 1'b0;
                end else if (CEP) begin
                    r_pd_past  <= r_pd;
                    r_pbd_past <= r_pbd;
                end
            end

            assign OVERFLOW  = r_pd_past  & ~r_pd & ~r_pbd;
            assign UNDERFLOW = r_pbd_past & ~r_pd & ~r_pbd;
`else
            assign OVERFLOW  = 1'b0;
            assign UNDERFLOW = 1'b0;
`endif

            assign P              = r_p;
            assign CARRYOUT       = r_carry;
            assign PATTERNDETECT  = r_pd;
            assign PATTERNBDETECT = r_pbd;
        end else begin : g_comb
            logic w_unused_ctrl;

            assign w_unused_ctrl  = RSTP ^ CEP ^ clk;
            assign P              = ALU_OUT;
            assign CARRYOUT       = CARRYOUT_IN;
            assign PATTERNDETECT  = w_pd_d;
            assign PATTERNBDETECT = w_pbd_d;
            assign OVERFLOW       = 1'b0;
            assign UNDERFLOW      = 1'b0;
        end
    endgenerate

    assign PCOUT = P;

endmodule : p_out_reg

`default_nettype wire

// File: tb/tb_p_out_reg.sv
// ============================================================================
//  Module      : tb_p_out_reg
//  Description : Directed scoreboard bench for p_out_reg across several
//                parameter sets sharing one stimulus bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_out_reg;

    localparam int N = 6;
`ifdef DSP_P_OVF_UNF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RSTP;
    logic        CEP;
    logic [47:0] ALU_OUT;
    logic [3:0]  CARRYOUT_IN;
    logic [47:0] C;

    logic [47:0] p_o   [N];
    logic [47:0] pc_o  [N];
    logic [3:0]  cy_o  [N];
    logic        pd_o  [N];
    logic        pbd_o [N];
    logic        ovf_o [N];
    logic        unf_o [N];

    always #5 clk = ~clk;

    // 0: static pattern FF / mask ..FF00, 1: overflow set, 2: auto-reset,
    // 3: combinational, 4: pattern and mask from C, 5: detect disabled
    p_out_reg #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0000_0000_00FF),
                .MASK(48'hFFFF_FFFF_FF00)) u0 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[0]), .PCOUT(pc_o[0]), .CARRYOUT(cy_o[0]), .PATTERNDETECT(pd_o[0]),
        .PATTERNBDETECT(pbd_o[0]), .OVERFLOW(ovf_o[0]), .UNDERFLOW(unf_o[0]));

    p_out_reg #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
                .MASK(48'hFFFF_FFFF_FE00)) u1 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[1]), .PCOUT(pc_o[1]), .CARRYOUT(cy_o[1]), .PATTERNDETECT(pd_o[1]),
        .PATTERNBDETECT(pbd_o[1]), .OVERFLOW(ovf_o[1]), .UNDERFLOW(unf_o[1]));

    p_out_reg #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0000_0000_000A),
                .MASK(48'h0), .AUTORESET_PATDET("RESET_MATCH")) u2 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[2]), .PCOUT(pc_o[2]), .CARRYOUT(cy_o[2]), .PATTERNDETECT(pd_o[2]),
        .PATTERNBDETECT(pbd_o[2]), .OVERFLOW(ovf_o[2]), .UNDERFLOW(unf_o[2]));

    p_out_reg #(.PREG(0), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0000_0000_00FF),
                .MASK(48'hFFFF_FFFF_FF00)) u3 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[3]), .PCOUT(pc_o[3]), .CARRYOUT(cy_o[3]), .PATTERNDETECT(pd_o[3]),
        .PATTERNBDETECT(pbd_o[3]), .OVERFLOW(ovf_o[3]), .UNDERFLOW(unf_o[3]));

    p_out_reg #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .SEL_PATTERN("C"), .SEL_MASK("C")) u4 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[4]), .PCOUT(pc_o[4]), .CARRYOUT(cy_o[4]), .PATTERNDETECT(pd_o[4]),
        .PATTERNBDETECT(pbd_o[4]), .OVERFLOW(ovf_o[4]), .UNDERFLOW(unf_o[4]));

    p_out_reg #(.PREG(1)) u5 (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT), .CARRYOUT_IN(CARRYOUT_IN), .C(C),
        .P(p_o[5]), .PCOUT(pc_o[5]), .CARRYOUT(cy_o[5]), .PATTERNDETECT(pd_o[5]),
        .PATTERNBDETECT(pbd_o[5]), .OVERFLOW(ovf_o[5]), .UNDERFLOW(unf_o[5]));

    typedef struct packed {
        logic [2:0]  k;
        logic [47:0] p;
        logic [3:0]  cy;
        logic        pd;
        logic        pbd;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk1(input string tag, input string fld, input logic [47:0] obs,
                        input logic [47:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        int    k;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        k = int'(e.k);
        chk1(t, "P",        p_o[k],            e.p);
        chk1(t, "PCOUT",    pc_o[k],           e.p);
        chk1(t, "CARRYOUT", {44'b0, cy_o[k]},  {44'b0, e.cy});
        chk1(t, "PD",       {47'b0, pd_o[k]},  {47'b0, e.pd});
        chk1(t, "PBD",      {47'b0, pbd_o[k]}, {47'b0, e.pbd});
        chk1(t, "OVF",      {47'b0, ovf_o[k]}, {47'b0, e.ovf});
        chk1(t, "UNF",      {47'b0, unf_o[k]}, {47'b0, e.unf});
    endtask

    task automatic push(input int k, input string tag, input logic [47:0] p, input logic [3:0] cy,
                        input logic pd, input logic pbd, input logic ovf, input logic unf);
        exp_t e;
        e.k = 3'(k); e.p = p; e.cy = cy; e.pd = pd; e.pbd = pbd; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic expect_next(input int k, input string tag, input logic [47:0] p,
                               input logic [3:0] cy, input logic pd, input logic pbd,
                               input logic ovf, input logic unf);
        push(k, tag, p, cy, pd, pbd, ovf, unf);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic expect_now(input int k, input string tag, input logic [47:0] p,
                              input logic [3:0] cy, input logic pd, input logic pbd,
                              input logic ovf, input logic unf);
        push(k, tag, p, cy, pd, pbd, ovf, unf);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTP = 1'b1; CEP = 1'b1; ALU_OUT = 48'h1234; CARRYOUT_IN = 4'hF; C = 48'h0;
        @(posedge clk); #1;

        // Reset held two cycles with data present
        expect_next(0, "rst1", 48'h0, 4'h0, 0, 0, 0, 0);
        expect_next(0, "rst2", 48'h0, 4'h0, 0, 0, 0, 0);
        expect_now (2, "rst_u2", 48'h0, 4'h0, 0, 0, 0, 0);

        RSTP = 1'b0; CARRYOUT_IN = 4'h5;
        expect_next(0, "load", 48'h1234, 4'h5, 0, 0, 0, 0);

        // Clock enable hold
        ALU_OUT = 48'h5; CARRYOUT_IN = 4'h3;
        expect_next(0, "ce_on", 48'h5, 4'h3, 0, 0, 0, 0);
        CEP = 1'b0; ALU_OUT = 48'h9; CARRYOUT_IN = 4'hA;
        expect_next(0, "hold1", 48'h5, 4'h3, 0, 0, 0, 0);
        expect_next(0, "hold2", 48'h5, 4'h3, 0, 0, 0, 0);

        // Pattern, pattern-bar, then underflow
        CEP = 1'b1; ALU_OUT = 48'hABCD_0000_00FF; CARRYOUT_IN = 4'h1;
        expect_next(0, "pd", 48'hABCD_0000_00FF, 4'h1, 1, 0, 0, 0);
        ALU_OUT = 48'h0; CARRYOUT_IN = 4'h0;
        expect_next(0, "pbd", 48'h0, 4'h0, 0, 1, 0, 0);
        expect_now (5, "nopat", 48'h0, 4'h0, 0, 0, 0, 0);
        ALU_OUT = 48'h55;
        expect_next(0, "unf", 48'h55, 4'h0, 0, 0, 0, OVF_EN);

        // Overflow on u1 (bits 8:0 compared against 0)
        RSTP = 1'b1;
        expect_next(1, "ovf_rst0", 48'h0, 4'h0, 0, 0, 0, 0);
        RSTP = 1'b0; ALU_OUT = 48'h0;
        expect_next(1, "ovf_a", 48'h0, 4'h0, 1, 0, 0, 0);
        ALU_OUT = 48'h100;
        expect_next(1, "ovf_b", 48'h100, 4'h0, 0, 0, OVF_EN, 0);
        ALU_OUT = 48'h0;
        expect_next(1, "ovf_c", 48'h0, 4'h0, 1, 0, 0, 0);
        expect_next(1, "ovf_d", 48'h0, 4'h0, 1, 0, 0, 0);
        RSTP = 1'b1;
        expect_next(1, "ovf_rst", 48'h0, 4'h0, 0, 0, 0, 0);
        RSTP = 1'b0; ALU_OUT = 48'h100;
        expect_next(1, "ovf_post", 48'h100, 4'h0, 0, 0, 0, 0);

        // Auto-reset on match (u2)
        RSTP = 1'b1;
        expect_next(2, "ar_rst0", 48'h0, 4'h0, 0, 0, 0, 0);
        RSTP = 1'b0; ALU_OUT = 48'hA; CARRYOUT_IN = 4'h2;
        expect_next(2, "ar1", 48'hA, 4'h2, 1, 0, 0, 0);
        expect_next(2, "ar2", 48'h0, 4'h0, 0, 0, OVF_EN, 0);
        expect_next(2, "ar3", 48'hA, 4'h2, 1, 0, 0, 0);
        expect_next(2, "ar4", 48'h0, 4'h0, 0, 0, OVF_EN, 0);
        expect_next(2, "ar5", 48'hA, 4'h2, 1, 0, 0, 0);
        RSTP = 1'b1;
        expect_next(2, "ar_rst", 48'h0, 4'h0, 0, 0, 0, 0);
        RSTP = 1'b0;
        expect_next(2, "ar6", 48'hA, 4'h2, 1, 0, 0, 0);
        expect_next(2, "ar7", 48'h0, 4'h0, 0, 0, OVF_EN, 0);

        // Combinational P (u3): reset and enable ignored
        RSTP = 1'b1; CEP = 1'b0; ALU_OUT = 48'hABCD_0000_00FF; CARRYOUT_IN = 4'h7;
        expect_now(3, "comb_pd", 48'hABCD_0000_00FF, 4'h7, 1, 0, 0, 0);
        ALU_OUT = 48'h1200; CARRYOUT_IN = 4'h8;
        expect_now(3, "comb_pbd", 48'h1200, 4'h8, 0, 1, 0, 0);

        // Pattern and mask from C (u4), then all-ones mask
        CEP = 1'b1;
        expect_next(4, "c_rst", 48'h0, 4'h0, 0, 0, 0, 0);
        RSTP = 1'b0; C = 48'hFFFF_FFFF_FF00; ALU_OUT = 48'h1_2300; CARRYOUT_IN = 4'h9;
        expect_next(4, "c_pd", 48'h1_2300, 4'h9, 1, 0, 0, 0);
        ALU_OUT = 48'hFF;
        expect_next(4, "c_pbd", 48'hFF, 4'h9, 0, 1, 0, 0);
        C = 48'hFFFF_FFFF_FFFF; ALU_OUT = 48'h1234_5678_9ABC; CARRYOUT_IN = 4'hC;
        expect_next(4, "mask1_a", 48'h1234_5678_9ABC, 4'hC, 1, 1, 0, 0);
        expect_next(4, "mask1_b", 48'h1234_5678_9ABC, 4'hC, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_p_out_reg

`default_nettype wire
